// File: rtl/wb_fetch_pkg.sv
// Shared types and constants for the two-requester Wishbone block-prefetch scheduler.
package wb_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fetchState_e;

  localparam int NREQ = 2;
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter with a one-hot grant. The pointer moves to the
// requester that lost whenever a grant is taken.
module wb_rr_arbiter
  import wb_fetch_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = '0;
    if (req_i[REQ0] && (!req_i[REQ1] || !ptr_q)) begin
      gnt_o[REQ0] = 1'b1;
    end else if (req_i[REQ1]) begin
      gnt_o[REQ1] = 1'b1;
    end
  end

  assign ptr_d = (adv_i && (|gnt_o)) ? gnt_o[REQ0] : ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_fetch_sched.sv
// Shares one Wishbone B4 pipelined read master between two block-prefetch
// requesters: round-robin grant, BSIZE-word burst from the winner's base address.
module wb_fetch_sched
  import wb_fetch_pkg::*;
#(
  parameter int BSIZE = 24,
  parameter int BBITS = 5,
  parameter int ABITS = 12,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [ABITS-1:0] adr_o,
  input  logic             ack_i,
  input  logic             wat_i,
  input  logic             rty_i,
  input  logic             err_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic [NREQ-1:0]  req_i,
  input  logic [ABITS-1:0] base0_i,
  input  logic [ABITS-1:0] base1_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o,
  output logic [NREQ-1:0]  done_o,
  output logic             fail_o
);

  fetchState_e      state_q, state_d;
  logic             cyc_q, cyc_d, stb_q, stb_d;
  logic             vld_q, vld_d, fail_q, fail_d;
  logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d;
  logic [ABITS-1:0] base_q, base_d, adr_q, adr_d;
  logic [BBITS-1:0] off_q, off_d, ackCnt_q, ackCnt_d, offInc;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [NREQ-1:0]  arbGnt;
  logic             grant, accept, abort, ackHit;

  assign grant  = (state_q == IDLE) && (|req_i);
  assign accept = stb_q && !wat_i;
  assign abort  = cyc_q && (err_i || rty_i);
  assign ackHit = cyc_q && ack_i && !abort;
  assign offInc = off_q + BBITS'(1);

  wb_rr_arbiter u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_i),
    .adv_i (grant),
    .gnt_o (arbGnt)
  );

  // An abort wins over a coincident ack, so the aborted cycle never produces vld_o.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    gnt_d    = gnt_q;
    base_d   = base_q;
    adr_d    = adr_q;
    off_d    = off_q;
    ackCnt_d = ackCnt_q;
    dat_d    = dat_q;
    vld_d    = 1'b0;
    done_d   = '0;
    fail_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d  = BUSY;
          gnt_d    = arbGnt;
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          base_d   = arbGnt[REQ1] ? base1_i : base0_i;
          adr_d    = arbGnt[REQ1] ? base1_i : base0_i;
          off_d    = '0;
          ackCnt_d = '0;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          gnt_d   = '0;
          done_d  = gnt_q;
          fail_d  = 1'b1;
        end else begin
          if (accept) begin
            off_d = offInc;
            adr_d = base_q + ABITS'(offInc);
            if (off_q == BBITS'(BSIZE - 1)) begin
              stb_d = 1'b0;
            end
          end
          if (ackHit) begin
            ackCnt_d = ackCnt_q + BBITS'(1);
            vld_d    = 1'b1;
            dat_d    = dat_i;
            if (ackCnt_q == BBITS'(BSIZE - 1)) begin
              state_d = DONE;
              cyc_d   = 1'b0;
              stb_d   = 1'b0;
              gnt_d   = '0;
              done_d  = gnt_q;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      gnt_q    <= '0;
      base_q   <= '0;
      adr_q    <= '0;
      off_q    <= '0;
      ackCnt_q <= '0;
      dat_q    <= '0;
      vld_q    <= 1'b0;
      done_q   <= '0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      gnt_q    <= gnt_d;
      base_q   <= base_d;
      adr_q    <= adr_d;
      off_q    <= off_d;
      ackCnt_q <= ackCnt_d;
      dat_q    <= dat_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
    end
  end

  assign cyc_o  = cyc_q;
  assign stb_o  = stb_q;
  assign we_o   = 1'b0;
  assign adr_o  = adr_q;
  assign gnt_o  = gnt_q;
  assign vld_o  = vld_q;
  assign dat_o  = dat_q;
  assign done_o = done_q;
  assign fail_o = fail_q;

endmodule

// File: tb/tb_wb_fetch_sched.sv
// Scoreboard bench for wb_fetch_sched: a responding Wishbone slave model pushes
// expected words and burst endings; a monitor pops and compares what the DUT presents.
module tb_wb_fetch_sched;

  localparam int BSIZE = 24;
  localparam int BBITS = 5;
  localparam int ABITS = 12;
  localparam int WIDTH = 32;

  typedef struct {
    logic [1:0] owner;
    logic       fail;
    int         due;
  } doneExp_t;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             cyc_o, stb_o, we_o;
  logic [ABITS-1:0] adr_o;
  logic             ack_i, wat_i, rty_i, err_i;
  logic [WIDTH-1:0] dat_i;
  logic [1:0]       req_i;
  logic [ABITS-1:0] base0_i, base1_i;
  logic [1:0]       gnt_o;
  logic             vld_o;
  logic [WIDTH-1:0] dat_o;
  logic [1:0]       done_o;
  logic             fail_o;

  int testsRun = 0;
  int testsFailed = 0;
  int cycNum = 0;
  int doneSeenCnt = 0;
  int modelPtr = 0;

  logic [31:0] expDataQ[$];
  logic [1:0]  expGntQ[$];
  doneExp_t    expDoneQ[$];

  bit               slvEn = 1'b0;
  logic [ABITS-1:0] curBase = '0;
  logic [1:0]       curOwner = '0;
  int               errAt = 0;
  bit               useRty = 1'b0;
  int               stallMode = 0;
  int               acceptedCnt = 0;
  int               ackCnt = 0;
  int               outstanding = 0;
  int               burstCyc = 0;

  wb_fetch_sched #(
    .BSIZE(BSIZE),
    .BBITS(BBITS),
    .ABITS(ABITS),
    .WIDTH(WIDTH)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .cyc_o  (cyc_o),
    .stb_o  (stb_o),
    .we_o   (we_o),
    .adr_o  (adr_o),
    .ack_i  (ack_i),
    .wat_i  (wat_i),
    .rty_i  (rty_i),
    .err_i  (err_i),
    .dat_i  (dat_i),
    .req_i  (req_i),
    .base0_i(base0_i),
    .base1_i(base1_i),
    .gnt_o  (gnt_o),
    .vld_o  (vld_o),
    .dat_o  (dat_o),
    .done_o (done_o),
    .fail_o (fail_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    forever begin
      @(posedge clk_i);
      cycNum++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycNum);
    end
  endtask

  // Slave model: decides stall/ack/abort for the coming edge and records what the DUT must return.
  initial begin
    bit          doAck, doWat, acc;
    logic [11:0] expAdr;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; wat_i = 1'b0; dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i || !slvEn || !cyc_o) begin
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; wat_i = 1'b0;
        burstCyc = 0;
      end else begin
        burstCyc++;
        doAck = (outstanding > 0) && (stallMode != 2 || $urandom_range(0, 9) < 6);
        case (stallMode)
          1:       doWat = (burstCyc >= 3) && (burstCyc <= 5);
          2:       doWat = $urandom_range(0, 9) < 3;
          default: doWat = 1'b0;
        endcase
        acc = stb_o && !doWat;
        wat_i = doWat;
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        dat_i = $urandom;
        if (acc) begin
          expAdr = curBase + 12'(acceptedCnt);
          checkOutput("strobeBound", 32'(acceptedCnt < BSIZE), 1);
          checkOutput("adr", 32'(adr_o), 32'(expAdr));
          acceptedCnt++;
        end
        if (doAck) begin
          ackCnt++;
          outstanding--;
          ack_i = 1'b1;
          if (ackCnt == errAt) begin
            if (useRty) rty_i = 1'b1;
            else        err_i = 1'b1;
            expDoneQ.push_back('{owner: curOwner, fail: 1'b1, due: cycNum + 1});
          end else begin
            expDataQ.push_back(dat_i);
            if (ackCnt == BSIZE) begin
              expDoneQ.push_back('{owner: curOwner, fail: 1'b0, due: cycNum + 1});
            end
          end
        end
        if (acc) outstanding++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT starts a burst, returns a word or ends a burst.
  initial begin
    bit       prevCyc;
    doneExp_t e;
    prevCyc = 1'b0;
    forever begin
      @(negedge clk_i);
      if (cyc_o && !prevCyc) begin
        if (expGntQ.size() == 0) checkOutput("gntUnexpected", 32'(cyc_o), 0);
        else                     checkOutput("gnt", 32'(gnt_o), 32'(expGntQ.pop_front()));
      end
      prevCyc = cyc_o;
      if (vld_o) begin
        if (expDataQ.size() == 0) checkOutput("vldUnexpected", 32'(vld_o), 0);
        else                      checkOutput("vldData", dat_o, expDataQ.pop_front());
      end
      if (done_o != 2'b00) begin
        doneSeenCnt++;
        if (expDoneQ.size() == 0) begin
          checkOutput("doneUnexpected", 32'(done_o), 0);
        end else begin
          e = expDoneQ.pop_front();
          checkOutput("doneOwner", 32'(done_o), 32'(e.owner));
          checkOutput("failFlag", 32'(fail_o), 32'(e.fail));
          checkOutput("doneCycle", cycNum, e.due);
        end
      end else begin
        if (fail_o) checkOutput("failAlone", 32'(fail_o), 0);
        if (expDoneQ.size() > 0 && expDoneQ[0].due < cycNum) begin
          e = expDoneQ.pop_front();
          checkOutput("doneMissing", 32'(done_o), 32'(e.owner));
        end
      end
    end
  end

  // Issues one block request; the expected winner comes from a plain round-robin pointer.
  task automatic applyStimulus(input logic [1:0] mask, input logic [11:0] b0, input logic [11:0] b1,
                               input int mode, input int errIdx, input bit rty,
                               input bit dropEarly, input bit waitDone);
    int winner;
    int startDone;
    bit seen;
    if (mask == 2'b11) winner = modelPtr;
    else               winner = (mask == 2'b01) ? 0 : 1;
    modelPtr = 1 - winner;
    curOwner = (winner == 0) ? 2'b01 : 2'b10;
    expGntQ.push_back(curOwner);
    curBase = (winner == 0) ? b0 : b1;
    errAt = errIdx; useRty = rty; stallMode = mode;
    acceptedCnt = 0; ackCnt = 0; outstanding = 0;
    slvEn = 1'b1;
    startDone = doneSeenCnt;
    @(negedge clk_i); #2;
    base0_i = b0; base1_i = b1; req_i = mask;
    @(negedge clk_i); #2;
    checkOutput("reqLatency", 32'({cyc_o, stb_o}), 3);
    base0_i = 12'($urandom); base1_i = 12'($urandom);
    if (waitDone) begin
      if (dropEarly) begin
        repeat (3) @(negedge clk_i);
        #2 req_i = 2'b00;
      end
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk_i); #2;
        if (doneSeenCnt != startDone) seen = 1'b1;
      end
      checkOutput("doneSeen", 32'(seen), 1);
      req_i = 2'b00;
      if (errIdx == 0) checkOutput("strobeCount", acceptedCnt, BSIZE);
      checkOutput("vldLeft", expDataQ.size(), 0);
      if (!seen) begin
        expDataQ.delete(); expDoneQ.delete(); expGntQ.delete();
      end
      repeat (2) @(negedge clk_i);
    end
  endtask

  initial begin
    logic [1:0] mask;
    int         eIdx;
    rst_i = 1'b1;
    req_i = 2'b00; base0_i = '0; base1_i = '0;
    #12;
    checkOutput("rstCyc",  32'(cyc_o),  0);
    checkOutput("rstStb",  32'(stb_o),  0);
    checkOutput("rstGnt",  32'(gnt_o),  0);
    checkOutput("rstVld",  32'(vld_o),  0);
    checkOutput("rstDone", 32'(done_o), 0);
    checkOutput("rstFail", 32'(fail_o), 0);
    checkOutput("rstAdr",  32'(adr_o),  0);
    checkOutput("rstWe",   32'(we_o),   0);
    @(negedge clk_i); #2 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("[TB] directed bursts");
    applyStimulus(2'b01, 12'h100, 12'h000, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b11, 12'h400, 12'h800, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b11, 12'h410, 12'h810, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b11, 12'h420, 12'h820, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b01, 12'h300, 12'h000, 1, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b10, 12'h000, 12'hFF0, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b01, 12'h040, 12'h000, 0, 10, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b10, 12'h000, 12'h7F8, 0, 5, 1'b1, 1'b0, 1'b1);
    applyStimulus(2'b10, 12'h000, 12'h500, 0, 0, 1'b0, 1'b1, 1'b1);

    $display("[TB] randomized bursts");
    for (int n = 0; n < 12; n++) begin
      mask = 2'($urandom_range(1, 3));
      eIdx = ($urandom_range(0, 3) == 0) ? $urandom_range(1, BSIZE) : 0;
      applyStimulus(mask, 12'($urandom), 12'($urandom), 2, eIdx,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("[TB] reset during burst");
    applyStimulus(2'b01, 12'h200, 12'h000, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk_i);
    checkOutput("midBurst", 32'(cyc_o), 1);
    #3;
    rst_i = 1'b1; slvEn = 1'b0; req_i = 2'b00;
    #1;
    checkOutput("asyncRstCyc", 32'(cyc_o), 0);
    checkOutput("asyncRstStb", 32'(stb_o), 0);
    checkOutput("asyncRstGnt", 32'(gnt_o), 0);
    expDataQ.delete(); expDoneQ.delete(); expGntQ.delete();
    modelPtr = 0;
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    applyStimulus(2'b11, 12'h600, 12'hA00, 0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(2'b10, 12'h000, 12'hC00, 2, 0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
